// File: rtl/instruction_fetch_controller.sv
// Instruction fetch sequencer for a 256x8 instruction memory read on the clock negedge.
// Optional macro HALT_DETECT_EN enables stopping when HALT_OPCODE is fetched.
module instruction_fetch_controller #(
    parameter logic [7:0] RESET_PC    = 8'h00,
    parameter logic [7:0] HALT_OPCODE = 8'h00
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       start,
    output logic [7:0] endereco,
    input  logic [7:0] instrucao,
    output logic [7:0] instr_out,
    output logic [7:0] instr_pc,
    output logic       instr_valid,
    input  logic       instr_ready,
    input  logic       branch_taken,
    input  logic [7:0] branch_target,
    output logic       halted,
    output logic [1:0] state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        HALT = 2'b10
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [7:0] pc;
    logic       capture;
    logic       halt_hit;

    // Handshake: a word transfers at a posedge where instr_valid & instr_ready;
    // instr_valid never drops without a transfer except on branch or reset.
    assign capture   = (state == RUN) && (!instr_valid || instr_ready) && !branch_taken;
    assign endereco  = pc;
    assign state_dbg = state;

`ifdef HALT_DETECT_EN
    assign halt_hit = capture && (instrucao == HALT_OPCODE);
    assign halted   = (state == HALT);
`else
    wire unused_halt_opcode = ^HALT_OPCODE;
    assign halt_hit = 1'b0;
    assign halted   = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!branch_taken && start) state_nxt = RUN;
            RUN:     if (halt_hit) state_nxt = HALT;
            HALT:    if (start && !instr_valid) state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc          <= RESET_PC;
            instr_out   <= 8'h00;
            instr_pc    <= 8'h00;
            instr_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (branch_taken) pc <= branch_target;
                end
                RUN: begin
                    // A branch discards the held word even if it is being accepted now.
                    if (branch_taken) begin
                        pc          <= branch_target;
                        instr_valid <= 1'b0;
                    end else if (capture) begin
                        instr_out   <= instrucao;
                        instr_pc    <= pc;
                        instr_valid <= 1'b1;
                        pc          <= pc + 8'd1;
                    end
                end
                HALT: begin
                    if (instr_valid && instr_ready) instr_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/instruction_fetch_controller.md
Name: instruction_fetch_controller

Overview:
Sequences the 8-bit instruction memory (256 x 8, read on negedge of clock). It holds the program counter, drives the memory address, and captures the returned word on the following posedge. It then presents the word to the decode stage through a valid/ready handshake. It also handles branch redirects, program-counter wrap and halt-opcode detection.

Parameters:
RESET_PC, 8'h00, program counter value loaded on reset
HALT_OPCODE, 8'h00, instruction word that stops fetching (active only with HALT_DETECT_EN)

Ports:
clock  input  1  system clock; posedge-clocked logic, memory samples address on negedge
reset_n  input  1  asynchronous active-low reset
start  input  1  level; begins or resumes fetching
endereco  output  8  address to instruction memory; equals pc combinationally
instrucao  input  8  word from instruction memory; valid after negedge of the cycle endereco was driven
instr_out  output  8  registered instruction to decode
instr_pc  output  8  address instr_out was fetched from
instr_valid  output  1  instr_out holds an undelivered word
instr_ready  input  1  decode accepts word (handshake when instr_valid & instr_ready at posedge)
branch_taken  input  1  redirect request, sampled at posedge
branch_target  input  8  redirect address
halted  output  1  controller in HALT state

Behaviour:
- Reset (reset_n=0, asynchronous):
  - state=IDLE, pc=RESET_PC, instr_out=0, instr_pc=0, instr_valid=0, halted=0.
  - endereco=RESET_PC immediately.
- States: IDLE, RUN, HALT (2-bit register). endereco=pc in every state.
- capture = (state==RUN) & (!instr_valid | instr_ready) & !branch_taken.
- IDLE:
  - start=1 -> RUN next posedge; no capture in the transition cycle.
  - branch_taken=1 -> pc=branch_target, stay IDLE (branch has priority over start).
- RUN, evaluated in priority order at each posedge:
  1. branch_taken=1: pc=branch_target, instr_valid=0 (any held or in-flight word is discarded, including one being handshaken this cycle). No capture. First word from target is captured one posedge later.
  2. capture: instr_out=instrucao, instr_pc=pc, instr_valid=1, pc=pc+1 modulo 256 (8'hFF wraps to 8'h00).
  3. instr_valid & !instr_ready: hold instr_out, instr_pc and pc unchanged (stall).
  4. instr_valid & instr_ready without capture: cannot occur, because capture covers it.
- Throughput and latency: one word per cycle while instr_ready=1. Address driven in cycle N gives instr_valid=1 with that word after posedge ending cycle N (1-cycle fetch latency).
- start deasserted in RUN: no effect. Fetching continues until halt or reset.
- HALT:
  - halted=1. No captures; pc stays at halt word address + 1.
  - The halt word itself is delivered (instr_valid stays 1 until handshake, then 0).
  - branch_taken is ignored.
  - start=1 with instr_valid=0 -> RUN, halted=0 next posedge, fetching resumes at pc.
- Reset mid-operation: all state returns to reset values at once; a held word is lost; no handshake completes in that cycle.
- X on instrucao is captured as-is. The bench must not read unwritten locations.

Optional Feature:
HALT_DETECT_EN
- Defined: a capture whose instrucao==HALT_OPCODE performs the normal capture (word delivered, pc incremented) and moves to HALT the same posedge.
- Undefined: HALT_OPCODE is never compared, the HALT state is unreachable and halted is tied to 0. All words, including HALT_OPCODE, flow as normal instructions.

Test Plan:
- Reset then start, MEMI[0..2]=8'h11,8'h22,8'h33, instr_ready=1 -> instr_out 11,22,33 on consecutive cycles; instr_pc 0,1,2; endereco 0,1,2,3.
- Stall: ready=0 for 3 cycles after first capture -> instr_out=11, instr_pc=0, pc=1 held; ready=1 -> 22 next cycle, no word lost or duplicated.
- Branch to 8'd11 (MEMI[11]=8'h1C, MEMI[12]=8'hE0) while valid word held -> instr_valid=0 one cycle, then 1C@pc11, E0@pc12.
- Wrap: branch to 8'hFF, MEMI[255]=8'hAA, MEMI[0]=8'h11 -> AA@pc FF, then 11@pc 00.
- HALT_DETECT_EN: MEMI[22]=8'h00 after branch to 21 (MEMI[21]=8'h05) -> 05 then 00 delivered, halted=1, endereco=23 frozen; start=1 -> resumes at 23.
- Async reset asserted mid-RUN between edges -> instr_valid=0, endereco=RESET_PC, state IDLE before next clock edge.
